// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: default width,
// operation encodings, FSM states and small op-decode helpers.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Divide ops use restoring shift-subtract; the rest use shift-add.
    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    // Signed ops work on magnitudes and fix the sign at the end.
    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mdu_signfix.sv
// Conditional two's complement negation, modulo 2^W. Used both to take
// operand magnitudes and to apply the sign to product/quotient/remainder.
module mdu_signfix #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         neg,
    output logic [W-1:0] result
);

    // Negate when requested; -0x80..0 wraps to itself, which is the wanted magnitude.
    always_comb begin
        result = neg ? (~value + {{(W-1){1'b0}}, 1'b1}) : value;
    end

endmodule

// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// One radix-2 step per clock on operand magnitudes; signs applied on the
// final (FIN) edge. mthi/mtlo write srca directly when the unit is idle.
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt;
    logic                 div_r, neg_a, neg_b, dbz_r;
    logic [WIDTH-1:0]     opnd;       // multiplicand (mul) or divisor (div) magnitude
    logic [2*WIDTH-1:0]   acc;        // {partial product, multiplier} or {remainder, quotient}
    logic [2*WIDTH-1:0]   acc_step;
    logic [WIDTH:0]       mul_sum, div_shift, div_diff;

    logic [WIDTH-1:0]     abs_a, abs_b, quo_fix, rem_fix;
    logic [2*WIDTH-1:0]   prod_fix;
    logic                 accept, div_zero_req, sign_a, sign_b;

    assign accept       = (state == IDLE) && start;
    assign div_zero_req = op_is_div(op) && (srcb == '0);
    assign sign_a       = op_is_signed(op) && srca[WIDTH-1];
    assign sign_b       = op_is_signed(op) && srcb[WIDTH-1];

    mdu_signfix #(.W(WIDTH)) u_abs_a (.value(srca), .neg(sign_a), .result(abs_a));
    mdu_signfix #(.W(WIDTH)) u_abs_b (.value(srcb), .neg(sign_b), .result(abs_b));

    mdu_signfix #(.W(2*WIDTH)) u_prod (.value(acc), .neg(neg_a ^ neg_b), .result(prod_fix));
    mdu_signfix #(.W(WIDTH)) u_quo (.value(acc[WIDTH-1:0]), .neg(neg_a ^ neg_b), .result(quo_fix));
    mdu_signfix #(.W(WIDTH)) u_rem (.value(acc[2*WIDTH-1:WIDTH]), .neg(neg_a), .result(rem_fix));

    // One iteration step: shift-add for multiply, restoring shift-subtract for divide.
    always_comb begin
        // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + ({(WIDTH+1){acc[0]}} & {1'b0, opnd});
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        if (div_r) begin
            if (!div_diff[WIDTH]) begin
                acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_step = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_step = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic: divide by zero skips the iterations entirely.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = div_zero_req ? FIN : RUN;
            RUN:     if (cnt == CW'(1)) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: the unit stalls the pipeline whenever it is not idle.
    always_comb begin
        busy = (state != IDLE);
    end

    // Operand capture at accept and iteration datapath during RUN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            div_r <= 1'b0;
            neg_a <= 1'b0;
            neg_b <= 1'b0;
            dbz_r <= 1'b0;
            opnd  <= '0;
            acc   <= '0;
        end else if (accept) begin
            cnt   <= CW'(WIDTH);
            div_r <= op_is_div(op);
            neg_a <= sign_a;
            neg_b <= sign_b;
            dbz_r <= div_zero_req;
            opnd  <= op_is_div(op) ? abs_b : abs_a;
            acc   <= {{WIDTH{1'b0}}, (op_is_div(op) ? abs_a : abs_b)};
        end else if (state == RUN) begin
            cnt <= cnt - CW'(1);
            acc <= acc_step;
        end
    end

    // HI/LO writes and the done/div_by_zero pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    // start wins over mthi/mtlo; a zero divisor completes right away.
                    if (div_zero_req) begin
                        done        <= 1'b1;
                        div_by_zero <= 1'b1;
                    end
                end else begin
                    if (mthi) hi <= srca;
                    if (mtlo) lo <= srca;
                end
            end else if ((state == FIN) && !dbz_r) begin
                done <= 1'b1;
                if (div_r) begin
                    lo <= quo_fix;
                    hi <= rem_fix;
                end else begin
                    {hi, lo} <= prod_fix;
                end
            end
        end
    end

endmodule

// File: tb/tb_mdu_hilo.sv
// Bench for mdu_hilo: directed cases plus randomized ops. Expected HI/LO
// come from plain integer arithmetic and are queued at issue; a monitor
// pops and compares whenever done pulses.
module tb_mdu_hilo;
    import mdu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start, mthi, mtlo;
    logic [1:0]   op;
    logic [W-1:0] srca, srcb;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    mdu_hilo #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .srca(srca), .srcb(srcb), .mthi(mthi), .mtlo(mtlo),
        .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } exp_t;

    exp_t         sb_q[$];
    int           n_tests = 0;
    int           n_fail  = 0;
    int           cyc     = 0;
    int           c0      = 0;
    int           done_cyc = -1;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Architectural reference: HI/LO after an op, from integer arithmetic.
    function automatic exp_t ref_model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        e;
        longint      sa, sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.dbz = 1'b0;
        case (o)
            OP_MULT: begin
                p = sa * sb;
                m_hi = p[63:32]; m_lo = p[31:0];
            end
            OP_MULTU: begin
                p = {32'b0, a} * {32'b0, b};
                m_hi = p[63:32]; m_lo = p[31:0];
            end
            OP_DIV: begin
                if (b == '0) e.dbz = 1'b1;
                else begin
                    m_lo = 32'(sa / sb);
                    m_hi = 32'(sa % sb);
                end
            end
            default: begin
                if (b == '0) e.dbz = 1'b1;
                else begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
        endcase
        e.hi = m_hi;
        e.lo = m_lo;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (done) begin
                    done_cyc = cyc;
                    if (sb_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_done: got done=1, expected no pending op");
                    end else begin
                        e = sb_q.pop_front();
                        check("result_hi", hi, e.hi);
                        check("result_lo", lo, e.lo);
                        check("result_dbz", div_by_zero, e.dbz);
                    end
                end else if (div_by_zero) begin
                    n_fail++;
                    $display("FAIL dbz_without_done: got div_by_zero=1, expected 0");
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // Issue one op in IDLE; leaves the bench at the negedge after the accept edge.
    task automatic launch(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic mh, input logic ml);
        int k;
        k = 0;
        @(negedge clk);
        while (busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k == 100) begin
            n_fail++;
            $display("FAIL idle_wait: got busy=1, expected idle within 100 cycles");
        end
        start = 1'b1; op = o; srca = a; srcb = b; mthi = mh; mtlo = ml;
        sb_q.push_back(ref_model(o, a, b));
        done_cyc = -1;
        @(posedge clk);
        #1 c0 = cyc;
        @(negedge clk);
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        srca = $urandom; srcb = $urandom; op = 2'($urandom_range(0, 3));
    endtask

    // Count busy cycles from the accept edge, optionally poking start/mtlo mid-op.
    task automatic finish_op(input int exp_busy, input int exp_lat, input bit inject, input string tag);
        int n;
        n = 0;
        while (busy && n < 100) begin
            if (inject && n == 5) begin
                start = 1'b1; op = OP_DIVU; srca = 32'hDEADBEEF; srcb = 32'd5; mtlo = 1'b1; mthi = 1'b1;
            end else if (inject && n == 6) begin
                start = 1'b0; mtlo = 1'b0; mthi = 1'b0;
            end
            n++;
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, 64'(n), 64'(exp_busy));
        @(negedge clk);
        check({tag, "_done_latency"}, 64'(done_cyc - c0 + 1), 64'(exp_lat));
    endtask

    task automatic directed(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic mh, input logic [W-1:0] eh,
                            input logic [W-1:0] el, input bit inject);
        bit dz;
        dz = op_is_div(o) && (b == '0);
        launch(o, a, b, mh, 1'b0);
        finish_op(dz ? 1 : 33, dz ? 1 : 34, inject, tag);
        check({tag, "_hi"}, hi, eh);
        check({tag, "_lo"}, lo, el);
    endtask

    task automatic mt_write(input logic mh, input logic ml, input logic [W-1:0] v);
        @(negedge clk);
        mthi = mh; mtlo = ml; srca = v;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0; srca = $urandom;
        if (mh) m_hi = v;
        if (ml) m_lo = v;
        check("mt_hi", hi, m_hi);
        check("mt_lo", lo, m_lo);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 9))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'hFFFF_FFFE;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [1:0]   ro;
        logic [W-1:0] ra, rb;
        bit           dz;

        reset = 1'b1; start = 1'b0; op = 2'b00; srca = '0; srcb = '0; mthi = 1'b0; mtlo = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_dbz", div_by_zero, 0);
        check("reset_hi", hi, 0);
        check("reset_lo", lo, 0);
        reset = 1'b0;

        directed("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        directed("mult_neg3x7", OP_MULT, 32'hFFFFFFFD, 32'd7, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
        directed("mult_minxmin", OP_MULT, 32'h80000000, 32'h80000000, 1'b0, 32'h40000000, 32'h0, 1'b0);
        directed("div_neg7by2", OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        directed("divu_100by7", OP_DIVU, 32'd100, 32'd7, 1'b0, 32'd2, 32'd14, 1'b0);
        directed("div_overflow", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h0, 32'h80000000, 1'b0);

        mt_write(1'b1, 1'b0, 32'h11111111);
        mt_write(1'b0, 1'b1, 32'h22222222);
        directed("div_by_zero", OP_DIV, 32'h00001234, 32'h0, 1'b0, 32'h11111111, 32'h22222222, 1'b0);

        directed("mult_ignore_req", OP_MULT, 32'h00010003, 32'h00000100, 1'b0, 32'h0, 32'h01000300, 1'b0 | 1'b1);
        check("idle_after_ignored_start", busy, 0);
        mt_write(1'b1, 1'b0, 32'h12345678);
        check("mthi_value", hi, 32'h12345678);
        check("mthi_lo_kept", lo, 32'h01000300);
        directed("start_drops_mthi", OP_DIVU, 32'hCAFEF00D, 32'h0, 1'b1, 32'h12345678, 32'h01000300, 1'b0);
        mt_write(1'b1, 1'b1, 32'hA5A5A5A5);

        // Asynchronous reset in the middle of a divide.
        launch(OP_DIVU, 32'hF00DBABE, 32'h00000013, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("midop_reset_busy", busy, 0);
        check("midop_reset_hi", hi, 0);
        check("midop_reset_lo", lo, 0);
        check("midop_reset_done", done, 0);
        sb_q.delete();
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("post_reset_idle", busy, 0);
        directed("divu_9by3", OP_DIVU, 32'd9, 32'd3, 1'b0, 32'd0, 32'd3, 1'b0);

        // Randomized ops with occasional zero divisors and idle mthi/mtlo writes.
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = pick();
            rb = ($urandom_range(0, 7) == 0) ? 32'h0 : pick();
            dz = op_is_div(ro) && (rb == '0);
            launch(ro, ra, rb, 1'b0, 1'b0);
            finish_op(dz ? 1 : 33, dz ? 1 : 34, 1'b0, "rand");
            if ($urandom_range(0, 3) == 0) mt_write(1'($urandom), 1'($urandom), $urandom);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
